frame_seq_ctrl: RTL
===================

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 SHALL have parameter c_timeout, default 16384, the number of RUN cycles allowed before abort (at least 2).
REQ-002 SHALL have parameter c_nb_cnt, default 16, the width of frame_cnt.
REQ-003 SHALL have parameter c_nb_drop, default 8, the width of drop_cnt.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cam_frame_end, input, 1 bit: 1-cycle pulse meaning the camera finished writing buffer cam_wbuf.
REQ-007 SHALL have port proc_done, input, 1 bit: 1-cycle pulse meaning the image processor finished the current frame.
REQ-008 SHALL have port rgbfilter_in, input, 3 bits: the requested filter code.
REQ-009 SHALL have port cam_wbuf, output, 1 bit: index of the input buffer the camera writes.
REQ-010 SHALL have port proc_rbuf, output, 1 bit: index of the input buffer the processor reads.
REQ-011 SHALL have port proc_start, output, 1 bit: 1-cycle start pulse to the processor.
REQ-012 SHALL have port rgbfilter, output, 3 bits: the filter code latched per frame.
REQ-013 SHALL have port busy, output, 1 bit: high while in START or RUN.
REQ-014 SHALL have port frame_cnt, output, c_nb_cnt bits: count of completed frames.
REQ-015 SHALL have port drop_cnt, output, c_nb_drop bits: count of dropped frames.
REQ-016 SHALL have port err_timeout, output, 1 bit: sticky flag, set on processing timeout.

Function
REQ-017 SHALL implement a ping-pong controller with states IDLE, START and RUN; cam_wbuf SHALL always equal ~proc_rbuf.
REQ-018 SHALL, in IDLE with cam_frame_end=1, accept the frame at that edge:
- swap the buffers (proc_rbuf takes the old cam_wbuf);
- latch rgbfilter from rgbfilter_in;
- move to START.
REQ-019 SHALL, in START, drive proc_start=1 for exactly that one cycle, then move to RUN.
REQ-020 SHALL, in RUN, hold proc_start=0, count cycles, and on proc_done=1:
- increment frame_cnt (wrap-around at 2^c_nb_cnt);
- move to IDLE.
REQ-021 SHALL, in START or RUN with cam_frame_end=1 and no simultaneous completion, drop the frame:
- no swap;
- increment drop_cnt, saturating at all-ones;
- the camera overwrites the same buffer.
REQ-022 SHALL, in RUN with proc_done=1 and cam_frame_end=1 in the same cycle:
- count the completion;
- accept the new frame per REQ-018 (swap, latch, go to START);
- not count a drop.
REQ-023 SHALL ignore proc_done outside RUN.
REQ-024 SHALL, if the RUN cycle counter reaches c_timeout-1 without proc_done:
- set err_timeout;
- return to IDLE;
- not increment frame_cnt.
A proc_done on that same cycle SHALL win, with no error.
REQ-025 SHALL, on a timeout cycle with cam_frame_end=1, accept the frame per REQ-018.
REQ-026 SHALL keep rgbfilter stable from acceptance until the next acceptance; changes on rgbfilter_in at other times SHALL have no effect.
REQ-027 SHALL give a latency of 1 cycle from an accepting cam_frame_end edge to proc_start=1.
REQ-028 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-029 SHALL reset the RUN cycle counter on every entry to RUN.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, set:
- state IDLE;
- cam_wbuf=0, proc_rbuf=1;
- proc_start=0, busy=0;
- rgbfilter=000;
- frame_cnt=0, drop_cnt=0;
- err_timeout=0;
- RUN cycle counter=0.
REQ-031 SHALL let reset during START or RUN abort the frame silently, with no proc_start and no count changes after the reset edge.
REQ-032 SHALL clear err_timeout only by rst.

Verification
REQ-033 SHALL pass: after reset, cam_frame_end pulse at cycle 10 with rgbfilter_in=100 -> at cycle 11: proc_start=1, cam_wbuf=1, proc_rbuf=0, rgbfilter=100; at cycle 12: busy=1.
REQ-034 SHALL pass: proc_done 50 cycles after proc_start -> frame_cnt=1, busy=0; a second cam_frame_end -> cam_wbuf=0, proc_rbuf=1.
REQ-035 SHALL pass: three cam_frame_end pulses while in RUN -> drop_cnt=3, with no buffer swap and no change on rgbfilter; with drop_cnt preset near saturation by 300 drops -> drop_cnt=255.
REQ-036 SHALL pass: proc_done and cam_frame_end in the same RUN cycle -> frame_cnt increments, proc_start=1 on the next cycle, buffers swap, drop_cnt unchanged.
REQ-037 SHALL pass: with c_timeout=8, no proc_done -> err_timeout=1 and IDLE after 8 RUN cycles with frame_cnt unchanged; err_timeout stays 1 across later frames until rst.
REQ-038 SHALL pass: rst asserted mid-RUN -> all outputs at reset values on the next cycle; a later proc_done has no effect.

Source files
------------

// File: rtl/frame_seq_ctrl_if.sv
// Signal bundle between the frame sequencer, the camera and the processor.
// master is the sequencer side, slave is the camera/processor side.
interface frame_seq_ctrl_if #(
    parameter int c_nb_cnt  = 16,
    parameter int c_nb_drop = 8
);
    logic                 cam_frame_end;
    logic                 proc_done;
    logic [2:0]           rgbfilter_in;
    logic                 cam_wbuf;
    logic                 proc_rbuf;
    logic                 proc_start;
    logic [2:0]           rgbfilter;
    logic                 busy;
    logic [c_nb_cnt-1:0]  frame_cnt;
    logic [c_nb_drop-1:0] drop_cnt;
    logic                 err_timeout;

    modport master (
        input  cam_frame_end, proc_done, rgbfilter_in,
        output cam_wbuf, proc_rbuf, proc_start, rgbfilter,
        output busy, frame_cnt, drop_cnt, err_timeout
    );

    modport slave (
        output cam_frame_end, proc_done, rgbfilter_in,
        input  cam_wbuf, proc_rbuf, proc_start, rgbfilter,
        input  busy, frame_cnt, drop_cnt, err_timeout
    );
endinterface

// File: rtl/frame_seq_ctrl.sv
// Ping-pong frame sequencer: hands finished camera buffers to the processor,
// drops frames arriving while busy and aborts processing on timeout.
module frame_seq_ctrl #(
    parameter int c_timeout = 16384,
    parameter int c_nb_cnt  = 16,
    parameter int c_nb_drop = 8
) (
    input  logic             clk,
    input  logic             rst,
    frame_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    localparam int c_nb_run = $clog2(c_timeout);
    localparam logic [c_nb_run-1:0] c_last = c_nb_run'(c_timeout - 1);

    state_t               state, state_n;
    logic [c_nb_run-1:0]  run_cnt, run_cnt_n;
    logic                 rbuf;
    logic [2:0]           filt;
    logic                 start;
    logic                 busy;
    logic [c_nb_cnt-1:0]  frames;
    logic [c_nb_drop-1:0] drops;
    logic                 err;
    logic                 done, tmo, accept, drop;

    always_comb begin
        state_n   = state;
        run_cnt_n = '0;
        done      = 1'b0;
        tmo       = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE:  accept = bus.cam_frame_end;
            START: state_n = RUN;
            RUN: begin
                done   = bus.proc_done;
                tmo    = !bus.proc_done && (run_cnt == c_last);
                accept = bus.cam_frame_end && (done || tmo);
                if (done || tmo)
                    state_n = IDLE;
                else
                    run_cnt_n = run_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // A frame ending while the processor is still occupied is lost
        drop = bus.cam_frame_end && !accept;
        if (accept)
            state_n = START;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            rbuf    <= 1'b1;
            filt    <= 3'b000;
            start   <= 1'b0;
            busy    <= 1'b0;
            frames  <= '0;
            drops   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            run_cnt <= run_cnt_n;
            start   <= (state_n == START);
            busy    <= (state_n != IDLE);
            if (accept) begin
                rbuf <= ~rbuf;
                filt <= bus.rgbfilter_in;
            end
            if (done)
                frames <= frames + 1'b1;
            if (drop && (drops != '1))
                drops <= drops + 1'b1;
            if (tmo)
                err <= 1'b1;
        end
    end

    assign bus.cam_wbuf    = ~rbuf;
    assign bus.proc_rbuf   = rbuf;
    assign bus.proc_start  = start;
    assign bus.rgbfilter   = filt;
    assign bus.busy        = busy;
    assign bus.frame_cnt   = frames;
    assign bus.drop_cnt    = drops;
    assign bus.err_timeout = err;
endmodule
